// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI read master port between an instruction-side (I) and a
// data-side (D) requester. One read transaction is outstanding at a time.
// When both sides request in the same IDLE cycle, they alternate.
//
// Parameters
//   I_SIZE  : arsize driven for I-side transactions
//   BURST   : constant arburst value
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   i_ar* / i_arready               : I-side request and its accept
//   i_r* / i_rready                 : I-side read data and its accept
//   d_ar* / d_arready               : D-side request (with size) and its accept
//   d_r* / d_rready                 : D-side read data and its accept
//   arid/araddr/arlen/arsize/
//   arburst/arvalid, arready        : AXI AR channel
//   rid/rdata/rlast/rvalid, rready  : AXI R channel
//   proto_err                       : sticky burst-length mismatch flag
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter logic [2:0] I_SIZE = 3'b010,
  parameter logic [1:0] BURST  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  // I side
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // D side
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // AXI master
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        proto_err
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADDR = 2'b01;
  localparam logic [1:0] DATA = 2'b10;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic        owner_d;   // 1 = D side owns the transaction, 0 = I side
  logic        last_d;    // 1 = D side won the most recent grant
  logic [7:0]  beat_q;
  logic        err_q;

  logic pick_d;
  logic pick_i;
  logic grant_ok;
  logic in_data;
  logic beat_acc;

  // Routing follows the latched owner only; the returned ID is not consulted.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Round-robin: on a conflict, the side that did not win last time goes.
  always_comb begin
    pick_d   = d_arvalid & (~i_arvalid | ~last_d);
    pick_i   = i_arvalid & ~pick_d;
    grant_ok = (state == IDLE) & ~rst;
  end

  assign i_arready = grant_ok & pick_i;
  assign d_arready = grant_ok & pick_d;

  assign in_data  = (state == DATA);
  assign beat_acc = rvalid & rready;

  // AR channel: fields hold their latched values outside ADDR.
  assign arvalid = (state == ADDR);
  assign arid    = {3'b000, owner_d};
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST;

  // R channel: only the owner sees beats, and only during DATA.
  assign rready   = in_data & (owner_d ? d_rready : i_rready);
  assign i_rvalid = in_data & ~owner_d & rvalid;
  assign i_rlast  = in_data & ~owner_d & rlast;
  assign i_rdata  = (in_data & ~owner_d) ? rdata : 32'd0;
  assign d_rvalid = in_data & owner_d & rvalid;
  assign d_rlast  = in_data & owner_d & rlast;
  assign d_rdata  = (in_data & owner_d) ? rdata : 32'd0;

  assign proto_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      owner_d <= 1'b0;
      last_d  <= 1'b1;   // so the I side wins the first conflict
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i | pick_d) begin
            addr_q  <= pick_d ? d_araddr : i_araddr;
            len_q   <= pick_d ? d_arlen  : i_arlen;
            size_q  <= pick_d ? d_arsize : I_SIZE;
            owner_d <= pick_d;
            last_d  <= pick_d;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            beat_q <= 8'd0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            beat_q <= beat_q + 8'd1;
            // rlast must coincide exactly with beat index == len
            if (rlast != (beat_q == len_q))
              err_q <= 1'b1;
            if (rlast)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed bench for axi_rd_arbiter. The AXI slave side is driven by hand
// from a linear sequence of steps; expected values are written inline.
// Inputs change 1 time unit after a rising edge, outputs are checked a
// further unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] d_araddr;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_arvalid;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_rvalid;
  logic        d_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.I_SIZE(3'b010), .BURST(2'b10)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_araddr = 32'd0; i_arlen = 8'd0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = 32'd0; d_arlen = 8'd0; d_arsize = 3'd0; d_arvalid = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
    tick();
    // ---- reset state; a request during reset must not be granted
    i_arvalid = 1'b1;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_i_arready", i_arready, 0);
    chk("rst_d_arready", d_arready, 0);
    chk("rst_araddr", araddr, 0);
    tick();

    // ---- both valid after reset: I wins the first conflict
    rst = 1'b0;
    i_araddr = 32'h1FC0_0000; i_arlen = 8'd7; i_arvalid = 1'b1;
    d_araddr = 32'h8000_0000; d_arlen = 8'd3; d_arsize = 3'b011; d_arvalid = 1'b1;
    #1;
    chk("first_i_arready", i_arready, 1);
    chk("first_d_arready", d_arready, 0);
    tick();
    i_arvalid = 1'b0;
    #1;
    chk("i_arvalid_up", arvalid, 1);
    chk("i_arid", arid, 0);
    chk("i_araddr", araddr, 32'h1FC0_0000);
    chk("i_arlen", arlen, 7);
    chk("i_arsize", arsize, 3'b010);
    chk("i_arburst", arburst, 2'b10);
    chk("addr_no_regrant_d", d_arready, 0);
    chk("addr_rready", rready, 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("data_arvalid_low", arvalid, 0);
    chk("data_araddr_hold", araddr, 32'h1FC0_0000);

    // ---- 8 beats to I, with a stall on beat 3; rid is deliberately wrong
    for (int k = 0; k < 8; k++) begin
      rvalid = 1'b1; rid = 4'h1; rdata = 32'hA000_0000 + k; rlast = (k == 7);
      if (k == 3) begin
        i_rready = 1'b0;
        #1;
        chk("stall_rready", rready, 0);
        chk("stall_i_rvalid", i_rvalid, 1);
        tick();
      end
      i_rready = 1'b1;
      #1;
      chk("i_beat_rdata", i_rdata, 32'hA000_0000 + k);
      chk("i_beat_rlast", i_rlast, (k == 7) ? 1 : 0);
      chk("i_beat_rvalid", i_rvalid, 1);
      chk("i_beat_d_rvalid", d_rvalid, 0);
      chk("i_beat_d_rdata", d_rdata, 0);
      chk("i_beat_rready", rready, 1);
      tick();
    end

    // ---- back in IDLE: stray beat ignored, D wins this conflict
    rlast = 1'b0; rdata = 32'hDEAD_BEEF;
    i_araddr = 32'h0000_0100; i_arlen = 8'd3; i_arvalid = 1'b1;
    #1;
    chk("idle_stray_i_rvalid", i_rvalid, 0);
    chk("idle_stray_rready", rready, 0);
    chk("burst_ok_err", proto_err, 0);
    chk("rr_d_arready", d_arready, 1);
    chk("rr_i_arready", i_arready, 0);
    tick();
    d_arvalid = 1'b0; rvalid = 1'b0;

    // ---- D in ADDR with arready held low for 5 cycles
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_arvalid", arvalid, 1);
      chk("hold_araddr", araddr, 32'h8000_0000);
      chk("hold_arid", arid, 1);
      chk("hold_arsize", arsize, 3'b011);
      chk("hold_arlen", arlen, 3);
      chk("hold_i_arready", i_arready, 0);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;

    // ---- 4 beats to D; rid carries the I id and must not matter
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rid = 4'h0; rdata = 32'hB000_0000 + k; rlast = (k == 3); d_rready = 1'b1;
      #1;
      chk("d_beat_rdata", d_rdata, 32'hB000_0000 + k);
      chk("d_beat_rvalid", d_rvalid, 1);
      chk("d_beat_i_rvalid", i_rvalid, 0);
      chk("d_beat_i_rdata", i_rdata, 0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;

    // ---- pending I request now granted; burst ends early (len 3, rlast on beat 1)
    #1;
    chk("pend_i_arready", i_arready, 1);
    chk("pend_d_err", proto_err, 0);
    tick();
    i_arvalid = 1'b0;
    #1;
    chk("i2_arid", arid, 0);
    chk("i2_araddr", araddr, 32'h0000_0100);
    chk("i2_arsize", arsize, 3'b010);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hC000_0000; rlast = 1'b0; i_rready = 1'b1;
    tick();
    rdata = 32'hC000_0001; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    d_araddr = 32'h0000_2000; d_arlen = 8'd7; d_arsize = 3'b001; d_arvalid = 1'b1;
    #1;
    chk("short_err", proto_err, 1);
    chk("short_idle_arvalid", arvalid, 0);
    chk("short_idle_grant", d_arready, 1);
    tick();
    d_arvalid = 1'b0;
    #1;
    chk("err_sticky", proto_err, 1);
    chk("d2_arsize", arsize, 3'b001);
    arready = 1'b1;
    tick();
    arready = 1'b0;

    // ---- reset on beat 2 of 8
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = 32'hE000_0000 + k; rlast = 1'b0; d_rready = 1'b1;
      tick();
    end
    rdata = 32'hE000_0002;
    #1;
    chk("pre_rst_d_rvalid", d_rvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_araddr = 32'h0000_3000; i_arlen = 8'd1; i_arvalid = 1'b1;
    d_araddr = 32'h0000_4000; d_arvalid = 1'b1;
    #1;
    chk("abort_arvalid", arvalid, 0);
    chk("abort_rready", rready, 0);
    chk("abort_d_rvalid", d_rvalid, 0);
    chk("abort_err", proto_err, 0);
    chk("abort_araddr", araddr, 0);
    chk("abort_arlen", arlen, 0);
    chk("abort_i_arready", i_arready, 1);
    chk("abort_d_arready", d_arready, 0);
    tick();
    i_arvalid = 1'b0; d_arvalid = 1'b0; rvalid = 1'b0;
    #1;
    chk("post_arvalid", arvalid, 1);
    chk("post_araddr", araddr, 32'h0000_3000);
    chk("post_arid", arid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
